// File: rtl/shift_sched_arbiter.sv
// Shares the two-stage FP add/sub barrel shifter between ALN and NRM.
// Define SHIFT_ARB_RR_EN for round-robin arbitration (default: NRM first).
module shift_sched_arbiter #(
  parameter int SWR = 26,
  parameter int EWR = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           aln_valid_i,
  output logic           aln_ready_o,
  input  logic [SWR-1:0] aln_data_i,
  input  logic [EWR-1:0] aln_shift_i,
  input  logic           aln_dir_i,
  input  logic           aln_fill_i,
  input  logic           nrm_valid_i,
  output logic           nrm_ready_o,
  input  logic [SWR-1:0] nrm_data_i,
  input  logic [EWR-1:0] nrm_shift_i,
  input  logic           nrm_dir_i,
  input  logic           nrm_fill_i,
  output logic [SWR-1:0] sh_data_o,
  output logic           sh_dir_o,
  output logic [EWR-1:0] sh_shift_o,
  output logic           sh_fill_o,
  output logic           sh_load_o,
  input  logic [SWR-1:0] sh_data_i,
  output logic           res_valid_o,
  input  logic           res_ready_i,
  output logic [SWR-1:0] res_data_o,
  output logic           res_tag_o,
  output logic           busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CAPT,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SWR-1:0] op_data;
  logic [EWR-1:0] op_shift;
  logic           op_dir;
  logic           op_fill;
  logic           op_tag;

  logic open_slot;
  logic sel_nrm;
  logic accept;

`ifdef SHIFT_ARB_RR_EN
  logic last_nrm;

  // On a tie the requester not granted last wins
  always_comb begin
    sel_nrm = nrm_valid_i & (~aln_valid_i | ~last_nrm);
  end

  // Remember who won the most recent acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      last_nrm <= 1'b0;
    end else if (accept) begin
      last_nrm <= sel_nrm;
    end
  end
`else
  // Fixed priority: NRM always beats ALN
  always_comb begin
    sel_nrm = nrm_valid_i;
  end
`endif

  // Readies go only to the winner, and only when a slot is free
  always_comb begin
    open_slot = ~rst & ((state == IDLE) |
                ((state == DONE) & res_ready_i));
    nrm_ready_o = open_slot & sel_nrm;
    aln_ready_o = open_slot & aln_valid_i & ~sel_nrm;
    accept = (nrm_valid_i & nrm_ready_o) |
             (aln_valid_i & aln_ready_o);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-state outputs
  always_comb begin
    state_nxt   = state;
    sh_load_o   = 1'b0;
    res_valid_o = 1'b0;
    busy_o      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = LOAD;
      end
      LOAD: begin
        sh_load_o = 1'b1;
        state_nxt = CAPT;
      end
      CAPT: begin
        state_nxt = DONE;
      end
      DONE: begin
        res_valid_o = 1'b1;
        if (res_ready_i) begin
          state_nxt = accept ? LOAD : IDLE;
        end
      end
    endcase
  end

  // Operands latch on acceptance and stay put through both stages
  always_ff @(posedge clk) begin
    if (rst) begin
      op_data  <= '0;
      op_shift <= '0;
      op_dir   <= 1'b0;
      op_fill  <= 1'b0;
      op_tag   <= 1'b0;
    end else if (accept) begin
      op_data  <= sel_nrm ? nrm_data_i  : aln_data_i;
      op_shift <= sel_nrm ? nrm_shift_i : aln_shift_i;
      op_dir   <= sel_nrm ? nrm_dir_i   : aln_dir_i;
      op_fill  <= sel_nrm ? nrm_fill_i  : aln_fill_i;
      op_tag   <= sel_nrm;
    end
  end

  // Second shifter stage settles in CAPT; grab it with its tag
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data_o <= '0;
      res_tag_o  <= 1'b0;
    end else if (state == CAPT) begin
      res_data_o <= sh_data_i;
      res_tag_o  <= op_tag;
    end
  end

  assign sh_data_o  = op_data;
  assign sh_shift_o = op_shift;
  assign sh_dir_o   = op_dir;
  assign sh_fill_o  = op_fill;

endmodule

// File: tb/tb_shift_sched_arbiter.sv
// Scoreboard bench for shift_sched_arbiter with a two-stage shifter model.
// Build with +define+SHIFT_ARB_RR_EN to check the round-robin variant.
module tb_shift_sched_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        aln_valid_i = 1'b0;
  logic        aln_ready_o;
  logic [25:0] aln_data_i = '0;
  logic [4:0]  aln_shift_i = '0;
  logic        aln_dir_i = 1'b0;
  logic        aln_fill_i = 1'b0;
  logic        nrm_valid_i = 1'b0;
  logic        nrm_ready_o;
  logic [25:0] nrm_data_i = '0;
  logic [4:0]  nrm_shift_i = '0;
  logic        nrm_dir_i = 1'b0;
  logic        nrm_fill_i = 1'b0;
  logic [25:0] sh_data_o;
  logic        sh_dir_o;
  logic [4:0]  sh_shift_o;
  logic        sh_fill_o;
  logic        sh_load_o;
  logic [25:0] sh_data_i;
  logic        res_valid_o;
  logic        res_ready_i = 1'b1;
  logic [25:0] res_data_o;
  logic        res_tag_o;
  logic        busy_o;

  shift_sched_arbiter #(.SWR(26), .EWR(5)) dut (
    .clk(clk), .rst(rst),
    .aln_valid_i(aln_valid_i), .aln_ready_o(aln_ready_o),
    .aln_data_i(aln_data_i), .aln_shift_i(aln_shift_i),
    .aln_dir_i(aln_dir_i), .aln_fill_i(aln_fill_i),
    .nrm_valid_i(nrm_valid_i), .nrm_ready_o(nrm_ready_o),
    .nrm_data_i(nrm_data_i), .nrm_shift_i(nrm_shift_i),
    .nrm_dir_i(nrm_dir_i), .nrm_fill_i(nrm_fill_i),
    .sh_data_o(sh_data_o), .sh_dir_o(sh_dir_o),
    .sh_shift_o(sh_shift_o), .sh_fill_o(sh_fill_o),
    .sh_load_o(sh_load_o), .sh_data_i(sh_data_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_tag_o(res_tag_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Whole-amount shift with fill into every vacated position
  function automatic logic [25:0] ref_shift(input logic [25:0] d,
      input int amt, input logic dir, input logic fill);
    longint unsigned m;
    longint unsigned x;
    longint unsigned r;
    m = 64'h3FF_FFFF;
    x = {38'd0, d};
    if (!dir) begin
      r = x >> amt;
      if (fill) r = r | (~(m >> amt) & m);
    end else begin
      r = (x << amt) & m;
      if (fill) r = r | ((64'd1 << amt) - 64'd1);
    end
    r = r & m;
    return r[25:0];
  endfunction

  // Shifter model: fine stage into mid register, coarse stage after it
  logic [25:0] mid = '0;
  always @(posedge clk)
    if (sh_load_o)
      mid <= ref_shift(sh_data_o, int'(sh_shift_o[2:0]),
                       sh_dir_o, sh_fill_o);
  assign sh_data_i = ref_shift(mid, int'({sh_shift_o[4:3], 3'b000}),
                               sh_dir_o, sh_fill_o);

  typedef struct packed {
    logic        tag;
    logic [25:0] data;
    int          due;
  } exp_t;

  typedef struct packed {
    logic [25:0] data;
    logic [4:0]  shift;
    logic        dir;
    logic        fill;
  } op_t;

  exp_t exp_q[$];
  logic acc_tags[$];
  int   pop_cyc[$];
  logic [25:0] last_data = '0;
  logic        last_tag = 1'b0;
  int   last_acc = -10;
  op_t  last_op = '0;
  logic last_grant = 1'b0;
  bit   seen = 0;
  bit   held = 0;
  logic [25:0] h_data = '0;
  logic        h_tag = 1'b0;

  // Monitor: handshake rules, result scoreboard, acceptance log
  always @(negedge clk) begin
    logic open;
    logic win_nrm;
    logic [1:0] exp_rdy;
    exp_t e;
    if (rst) begin
      exp_q.delete();
      last_acc   = -10;
      last_grant = 1'b0;
      seen = 0;
      held = 0;
    end else begin
      open = (exp_q.size() == 0) || (res_valid_o && res_ready_i);
`ifdef SHIFT_ARB_RR_EN
      win_nrm = (last_grant == 1'b0);
`else
      win_nrm = 1'b1;
`endif
      if (!open) exp_rdy = 2'b00;
      else if (aln_valid_i && nrm_valid_i)
        exp_rdy = win_nrm ? 2'b01 : 2'b10;
      else exp_rdy = {aln_valid_i, nrm_valid_i};
      chk("ready", 64'({aln_ready_o, nrm_ready_o}), 64'(exp_rdy));
      chk("busy", 64'(busy_o), 64'(exp_q.size() != 0));
      chk("sh_load", 64'(sh_load_o), 64'(cyc == last_acc + 1));
      if (cyc == last_acc + 1 || cyc == last_acc + 2)
        chk("sh_hold",
            64'({sh_data_o, sh_shift_o, sh_dir_o, sh_fill_o}),
            64'(last_op));
      if (res_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 64'(1), 64'(0));
        end else begin
          if (!seen) begin
            chk("latency", 64'(cyc), 64'(exp_q[0].due));
            seen = 1;
          end
          if (held)
            chk("bp_hold", 64'({res_tag_o, res_data_o}),
                64'({h_tag, h_data}));
          if (res_ready_i) begin
            e = exp_q.pop_front();
            chk("res_data", 64'(res_data_o), 64'(e.data));
            chk("res_tag", 64'(res_tag_o), 64'(e.tag));
            last_data = res_data_o;
            last_tag  = res_tag_o;
            pop_cyc.push_back(cyc);
            seen = 0;
            held = 0;
          end else begin
            held   = 1;
            h_data = res_data_o;
            h_tag  = res_tag_o;
          end
        end
      end
      if (aln_valid_i && aln_ready_o) begin
        e.tag  = 1'b0;
        e.data = ref_shift(aln_data_i, int'(aln_shift_i),
                           aln_dir_i, aln_fill_i);
        e.due  = cyc + 3;
        exp_q.push_back(e);
        acc_tags.push_back(1'b0);
        last_op = {aln_data_i, aln_shift_i, aln_dir_i, aln_fill_i};
        last_acc   = cyc;
        last_grant = 1'b0;
      end
      if (nrm_valid_i && nrm_ready_o) begin
        e.tag  = 1'b1;
        e.data = ref_shift(nrm_data_i, int'(nrm_shift_i),
                           nrm_dir_i, nrm_fill_i);
        e.due  = cyc + 3;
        exp_q.push_back(e);
        acc_tags.push_back(1'b1);
        last_op = {nrm_data_i, nrm_shift_i, nrm_dir_i, nrm_fill_i};
        last_acc   = cyc;
        last_grant = 1'b1;
      end
    end
  end

  task automatic drive_aln(input logic [25:0] d, input logic [4:0] s,
                           input logic dr, input logic f);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    aln_data_i = d; aln_shift_i = s;
    aln_dir_i = dr; aln_fill_i = f;
    aln_valid_i = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (aln_ready_o) begin ok = 1; break; end
    end
    chk("aln_accepted", 64'(ok), 64'(1));
    @(posedge clk); #1;
    aln_valid_i = 1'b0;
  endtask

  task automatic drive_nrm(input logic [25:0] d, input logic [4:0] s,
                           input logic dr, input logic f);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    nrm_data_i = d; nrm_shift_i = s;
    nrm_dir_i = dr; nrm_fill_i = f;
    nrm_valid_i = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (nrm_ready_o) begin ok = 1; break; end
    end
    chk("nrm_accepted", 64'(ok), 64'(1));
    @(posedge clk); #1;
    nrm_valid_i = 1'b0;
  endtask

  task automatic aln_rand();
    drive_aln(26'($urandom), 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic nrm_rand();
    drive_nrm(26'($urandom), 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy_o && exp_q.size() == 0 &&
          !aln_valid_i && !nrm_valid_i) begin
        ok = 1; break;
      end
    end
    chk("idle_reached", 64'(ok), 64'(1));
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"},
        64'({aln_ready_o, nrm_ready_o, sh_load_o, res_valid_o,
             res_tag_o, busy_o, sh_dir_o, sh_fill_o, sh_shift_o}),
        64'(0));
    chk({tag, "_sh_data"}, 64'(sh_data_o), 64'(0));
    chk({tag, "_res_data"}, 64'(res_data_o), 64'(0));
  endtask

  bit stop = 0;
  bit got;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("reset");

    drive_aln(26'h0000100, 5'd4, 1'b0, 1'b0);
    wait_idle();
    chk("aln_single_data", 64'(last_data), 64'(26'h0000010));
    chk("aln_single_tag", 64'(last_tag), 64'(0));

    drive_nrm(26'h0000001, 5'd25, 1'b1, 1'b0);
    wait_idle();
    chk("nrm_left_data", 64'(last_data), 64'(26'h2000000));
    chk("nrm_left_tag", 64'(last_tag), 64'(1));

    pulse_reset();
    acc_tags.delete();
    fork
      repeat (2) nrm_rand();
      repeat (2) aln_rand();
    join
    wait_idle();
    chk("tie_count", 64'(acc_tags.size()), 64'(4));
    if (acc_tags.size() == 4) begin
`ifdef SHIFT_ARB_RR_EN
      chk("tie_order", 64'({acc_tags[0], acc_tags[1],
          acc_tags[2], acc_tags[3]}), 64'(4'b1010));
`else
      chk("tie_order", 64'({acc_tags[0], acc_tags[1],
          acc_tags[2], acc_tags[3]}), 64'(4'b1100));
`endif
    end

    res_ready_i = 1'b0;
    aln_rand();
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid_o) begin got = 1; break; end
    end
    chk("bp_valid_seen", 64'(got), 64'(1));
    fork
      nrm_rand();
    join_none
    repeat (5) begin
      @(negedge clk);
      chk("bp_no_ready",
          64'({aln_ready_o, nrm_ready_o}), 64'(0));
    end
    @(posedge clk); #1 res_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_accept", 64'(nrm_ready_o), 64'(1));
    @(negedge clk);
    chk("bp_next_load", 64'({sh_load_o, res_valid_o}), 64'(2'b10));
    wait_idle();

    aln_rand();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("capt_reset");
    repeat (6) @(negedge clk);
    wait_idle();

    pop_cyc.delete();
    repeat (4) aln_rand();
    wait_idle();
    chk("b2b_count", 64'(pop_cyc.size()), 64'(4));
    for (int i = 1; i < pop_cyc.size(); i++)
      chk("b2b_gap", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'(3));

    fork
      begin
        fork
          repeat (30) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            aln_rand();
          end
          repeat (30) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            nrm_rand();
          end
        join
        stop = 1;
      end
      while (!stop) begin
        @(posedge clk); #1;
        res_ready_i = ($urandom_range(0, 3) != 0);
      end
    join
    res_ready_i = 1'b1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
